// File: rtl/ppg_pkg.sv
// Shared definitions for the PPG front-end model: parameter defaults, FSM states,
// setting/output records and the ADC saturation helper.
package ppg_pkg;

  localparam int RED_DC_DEF        = 100;
  localparam int IR_DC_DEF         = 120;
  localparam int RED_AC_DEF        = 40;
  localparam int IR_AC_DEF         = 60;
  localparam int COMP_SCALE_DEF    = 8;
  localparam int SHAPE_DIV_DEF     = 2;
  localparam int SETTLE_CYCLES_DEF = 8;
  localparam int PIPE_LAT          = 2;

  typedef enum logic {
    SETTLE = 1'b0,
    TRACK  = 1'b1
  } ppg_state_e;

  typedef struct packed {
    logic       red;
    logic       ir;
    logic [3:0] drive;
    logic [6:0] comp;
    logic [3:0] gain;
  } ppg_cfg_t;

  typedef struct packed {
    logic [7:0] adc;
    logic       hi;
    logic       lo;
  } ppg_out_t;

  function automatic ppg_out_t ppg_sat(input logic signed [20:0] amp);
    ppg_out_t o;
    o = '0;
    if (amp < 0) o.lo = 1'b1;
    else if (amp > 21'sd255) begin
      o.adc = 8'hFF;
      o.hi  = 1'b1;
    end else o.adc = amp[7:0];
    return o;
  endfunction

endpackage

// File: rtl/ppg_shape_gen.sv
// Free-running 8-bit triangle (0..255..0) stepping once every SHAPE_DIV clocks.
module ppg_shape_gen #(
  parameter int SHAPE_DIV = 2
) (
  input  logic       CLK,
  input  logic       rst_n,
  output logic [7:0] shape
);
  localparam int DW = (SHAPE_DIV > 1) ? $clog2(SHAPE_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic          down;
  logic          tick;

  assign tick = (div_cnt == DW'(SHAPE_DIV - 1));

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      shape   <= '0;
      down    <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DW'(1);
      if (tick) begin
        // Turn around at the rails so neither extreme is held for two steps
        if (!down) begin
          if (shape == 8'hFF) begin
            shape <= 8'hFE;
            down  <= 1'b1;
          end else shape <= shape + 8'd1;
        end else begin
          if (shape == 8'h00) begin
            shape <= 8'h01;
            down  <= 1'b0;
          end else shape <= shape - 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/ppg_frontend_model.sv
// PPG analog front-end model: LED photocurrent, offset DAC, PGA and saturating 8-bit ADC,
// gated by a settle FSM. Define PPG_NOISE_EN to add LFSR dither before the gain stage.
module ppg_frontend_model
  import ppg_pkg::*;
#(
  parameter int RED_DC        = RED_DC_DEF,
  parameter int IR_DC         = IR_DC_DEF,
  parameter int RED_AC        = RED_AC_DEF,
  parameter int IR_AC         = IR_AC_DEF,
  parameter int COMP_SCALE    = COMP_SCALE_DEF,
  parameter int SHAPE_DIV     = SHAPE_DIV_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       LED_RED,
  input  logic       LED_IR,
  input  logic [3:0] LED_DRIVE,
  input  logic [6:0] DC_Comp,
  input  logic [3:0] PGA_Gain,
  output logic [7:0] ADC,
  output logic       ADC_Valid,
  output logic       Sat_Hi,
  output logic       Sat_Lo
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  ppg_cfg_t            cfg, cfg_q;
  logic                primed, change;
  logic [7:0]          shape;
  logic [13:0]         pc;
  logic signed [15:0]  diff, diff_n;
  logic signed [20:0]  gain1, amp, amp_q;
  ppg_state_e          state, state_nx;
  logic [CW-1:0]       cnt, cnt_nx;
  logic                adc_en, track_ok;
  logic [PIPE_LAT-1:0] vld_pipe;
  ppg_out_t            sat_o;

  assign cfg = {LED_RED, LED_IR, LED_DRIVE, DC_Comp, PGA_Gain};

  // primed masks the first cycle after reset, when cfg_q holds reset zeros rather than a real setting
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q  <= '0;
      primed <= 1'b0;
    end else begin
      cfg_q  <= cfg;
      primed <= 1'b1;
    end
  end

  assign change = primed && (cfg != cfg_q);

  ppg_shape_gen #(.SHAPE_DIV(SHAPE_DIV)) u_shape (
    .CLK  (CLK),
    .rst_n(rst_n),
    .shape(shape)
  );

  always_comb begin
    pc = '0;
    if (cfg.red) pc = pc + 14'(RED_DC * cfg.drive + ((shape * RED_AC) >> 8));
    if (cfg.ir)  pc = pc + 14'(IR_DC * cfg.drive + ((shape * IR_AC) >> 8));
    diff = 16'(pc) - 16'(cfg.comp * COMP_SCALE);
  end

`ifdef PPG_NOISE_EN
  logic [15:0]        lfsr;
  logic signed [15:0] noise;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) lfsr <= 16'hACE1;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign noise  = {13'd0, lfsr[2:0]} - 16'd4;
  assign diff_n = diff + noise;
`else
  assign diff_n = diff;
`endif

  assign gain1 = {17'd0, cfg.gain} + 21'd1;
  assign amp   = 21'(diff_n) * gain1;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state <= SETTLE;
      cnt   <= CW'(SETTLE_CYCLES);
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Leave SETTLE on the edge where the count would hit zero, so a clean settle lasts SETTLE_CYCLES
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      SETTLE: begin
        if (change) cnt_nx = CW'(SETTLE_CYCLES);
        else if (cnt <= CW'(1)) begin
          cnt_nx   = '0;
          state_nx = TRACK;
        end else cnt_nx = cnt - CW'(1);
      end
      TRACK: begin
        if (change) begin
          state_nx = SETTLE;
          cnt_nx   = CW'(SETTLE_CYCLES);
        end
      end
      default: state_nx = SETTLE;
    endcase
  end

  always_comb begin
    adc_en   = (state == TRACK);
    track_ok = adc_en && !change;
  end

  assign sat_o = ppg_sat(amp_q);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      amp_q    <= '0;
      vld_pipe <= '0;
      ADC      <= '0;
      Sat_Hi   <= 1'b0;
      Sat_Lo   <= 1'b0;
    end else begin
      amp_q    <= amp;
      vld_pipe <= track_ok ? {vld_pipe[PIPE_LAT-2:0], 1'b1} : '0;
      if (adc_en) begin
        ADC    <= sat_o.adc;
        Sat_Hi <= sat_o.hi;
        Sat_Lo <= sat_o.lo;
      end
    end
  end

  assign ADC_Valid = vld_pipe[PIPE_LAT-1];

endmodule

// File: tb/tb_ppg_frontend_model.sv
// Bench for ppg_frontend_model (default build): constant vector table, settle/reset sequences,
// shape sweep and random settings against an edge-count reference model.
module tb_ppg_frontend_model;

  typedef struct {bit r; bit i; int d; int c; int g;} cfg_t;
  typedef struct {cfg_t cfg; int adc; bit hi; bit lo;} vec_t;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       LED_RED = 1'b0, LED_IR = 1'b0;
  logic [3:0] LED_DRIVE = '0, PGA_Gain = '0;
  logic [6:0] DC_Comp = '0;
  logic [7:0] ADC;
  logic       ADC_Valid, Sat_Hi, Sat_Lo;

  int n_vec = 0, n_bad = 0;
  // Model state: edges since reset release, edge of the latest setting change, pending amp
  int n_edge = 0, last_chg = 0, amp_prev = 0, exp_adc = 0;
  bit exp_hi = 1'b0, exp_lo = 1'b0;
  logic [16:0] x_prev = '0;

  ppg_frontend_model dut (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .LED_RED  (LED_RED),
    .LED_IR   (LED_IR),
    .LED_DRIVE(LED_DRIVE),
    .DC_Comp  (DC_Comp),
    .PGA_Gain (PGA_Gain),
    .ADC      (ADC),
    .ADC_Valid(ADC_Valid),
    .Sat_Hi   (Sat_Hi),
    .Sat_Lo   (Sat_Lo)
  );

  always #5 CLK = ~CLK;

  function automatic int tri_at(int k);
    int m;
    m = k % 510;
    return (m <= 255) ? m : 510 - m;
  endfunction

  function automatic int amp_of(cfg_t c, int s);
    int pc;
    pc = 0;
    if (c.r) pc += 100 * c.d + (s * 40) / 256;
    if (c.i) pc += 120 * c.d + (s * 60) / 256;
    return (pc - c.c * 8) * (c.g + 1);
  endfunction

  function automatic cfg_t rnd_cfg();
    cfg_t c;
    c.r = 1'($urandom_range(0, 1));
    c.i = 1'($urandom_range(0, 1));
    c.d = int'($urandom_range(0, 15));
    c.c = int'($urandom_range(0, 127));
    c.g = int'($urandom_range(0, 15));
    return c;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s (edge %0d): got %0d, expected %0d", name, n_edge, act, exp);
    end
  endtask

  // Called at a negedge; asserts reset between clock edges and checks outputs clear at once
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_adc", int'(ADC), 0);
    chk("rst_valid", int'(ADC_Valid), 0);
    chk("rst_hi", int'(Sat_Hi), 0);
    chk("rst_lo", int'(Sat_Lo), 0);
    @(negedge CLK);
    rst_n = 1'b1;
    n_edge = 0; last_chg = 0; amp_prev = 0; exp_adc = 0; exp_hi = 1'b0; exp_lo = 1'b0;
  endtask

  // Called at a negedge: drive settings, take one clock edge, advance the model, check at negedge
  task automatic step(input cfg_t c);
    logic [16:0] x;
    bit chg, was_track;
    LED_RED = c.r; LED_IR = c.i; LED_DRIVE = 4'(c.d); DC_Comp = 7'(c.c); PGA_Gain = 4'(c.g);
    x = {c.r, c.i, 4'(c.d), 7'(c.c), 4'(c.g)};
    @(posedge CLK);
    n_edge++;
    chg = (n_edge > 1) && (x != x_prev);
    was_track = (n_edge - 1 - last_chg) >= 8;
    if (was_track) begin
      exp_adc = (amp_prev < 0) ? 0 : (amp_prev > 255) ? 255 : amp_prev;
      exp_hi  = amp_prev > 255;
      exp_lo  = amp_prev < 0;
    end
    if (chg) last_chg = n_edge;
    amp_prev = amp_of(c, tri_at((n_edge - 1) / 2));
    x_prev = x;
    @(negedge CLK);
    chk("adc", int'(ADC), exp_adc);
    chk("sat_hi", int'(Sat_Hi), int'(exp_hi));
    chk("sat_lo", int'(Sat_Lo), int'(exp_lo));
    chk("valid", int'(ADC_Valid), int'(n_edge - last_chg >= 10));
  endtask

  task automatic steps_to_valid(input cfg_t c, input int ref_e, input int bound,
                                input int frz_until, input int frz, output int lat);
    lat = -1;
    for (int k = 0; k < bound && lat < 0; k++) begin
      step(c);
      if (n_edge <= frz_until) chk("freeze_adc", int'(ADC), frz);
      if (ADC_Valid) lat = n_edge - ref_e;
    end
  endtask

  initial begin
    vec_t tbl [10];
    cfg_t c0, c1, c2, cur;
    int   lat, e, frz, mn, mx;

    tbl[0] = '{'{1, 0, 10, 110, 0}, 120, 0, 0};
    tbl[1] = '{'{1, 0, 10, 110, 1}, 240, 0, 0};
    tbl[2] = '{'{1, 0, 10, 110, 3}, 255, 1, 0};
    tbl[3] = '{'{1, 0, 10, 127, 0}, 0, 0, 1};
    tbl[4] = '{'{0, 0, 9, 50, 4}, 0, 0, 1};
    tbl[5] = '{'{0, 0, 9, 0, 4}, 0, 0, 0};
    tbl[6] = '{'{0, 1, 2, 20, 2}, 240, 0, 0};
    tbl[7] = '{'{1, 1, 1, 27, 0}, 4, 0, 0};
    tbl[8] = '{'{1, 0, 15, 127, 15}, 255, 1, 0};
    tbl[9] = '{'{0, 1, 0, 0, 5}, 0, 0, 0};

    @(negedge CLK);
    foreach (tbl[t]) begin
      do_reset();
      steps_to_valid(tbl[t].cfg, 0, 14, -1, 0, lat);
      chk("tbl_latency", lat, 10);
      chk("tbl_adc", int'(ADC), tbl[t].adc);
      chk("tbl_hi", int'(Sat_Hi), int'(tbl[t].hi));
      chk("tbl_lo", int'(Sat_Lo), int'(tbl[t].lo));
    end

    // Gain change in TRACK, then a second change five cycles into the settle window
    c0 = '{1, 0, 10, 110, 0};
    c1 = c0; c1.g = 1;
    c2 = c0; c2.g = 2;
    do_reset();
    for (int k = 0; k < 12; k++) step(c0);
    step(c1);
    e = n_edge;
    chk("chg_valid_drop", int'(ADC_Valid), 0);
    frz = int'(ADC);
    steps_to_valid(c1, e, 14, e + 8, frz, lat);
    chk("relock_latency", lat, 10);
    step(c0);
    e = n_edge;
    frz = int'(ADC);
    for (int k = 0; k < 4; k++) begin
      step(c0);
      chk("freeze_adc", int'(ADC), frz);
    end
    step(c2);
    chk("freeze_adc", int'(ADC), frz);
    steps_to_valid(c2, e, 24, e + 13, frz, lat);
    chk("reload_latency", lat, 15);

    // Reset from TRACK, then reset from inside a settle window
    do_reset();
    steps_to_valid(c2, 0, 14, -1, 0, lat);
    chk("rst_track_latency", lat, 10);
    for (int k = 0; k < 4; k++) step(c1);
    do_reset();
    steps_to_valid(c1, 0, 14, -1, 0, lat);
    chk("rst_settle_latency", lat, 10);

    // Full triangle period with RED only, gain 1: swing must be 39*2
    c0 = '{1, 0, 1, 12, 1};
    do_reset();
    mn = 255; mx = 0;
    for (int k = 0; k < 1030; k++) begin
      step(c0);
      chk("shape", int'(dut.u_shape.shape), tri_at(n_edge / 2));
      if (ADC_Valid) begin
        if (int'(ADC) < mn) mn = int'(ADC);
        if (int'(ADC) > mx) mx = int'(ADC);
      end
    end
    chk("red_swing", mx - mn, 39 * 2);

    // Random settings with occasional resets
    do_reset();
    cur = rnd_cfg();
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 19) == 0) cur = rnd_cfg();
      step(cur);
      if (k % 500 == 499) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ppg_frontend_model.md
PPG_FRONTEND_MODEL -- requirements
Module: ppg_frontend_model

Interface
REQ-001 SHALL have parameter RED_DC, default 100, RED photocurrent per LED_DRIVE step.
REQ-002 SHALL have parameter IR_DC, default 120, IR photocurrent per LED_DRIVE step.
REQ-003 SHALL have parameter RED_AC, default 40, RED pulsatile amplitude.
REQ-004 SHALL have parameter IR_AC, default 60, IR pulsatile amplitude.
REQ-005 SHALL have parameter COMP_SCALE, default 8, photocurrent units per DC_Comp LSB.
REQ-006 SHALL have parameter SHAPE_DIV, default 2, clock cycles per pulse-shape step.
REQ-007 SHALL have parameter SETTLE_CYCLES, default 8, freeze time after an analog-setting change.
REQ-008 SHALL have ports: CLK in 1, clock; rst_n in 1, asynchronous active-low reset.
REQ-009 SHALL have ports: LED_RED in 1 and LED_IR in 1, LED enables.
REQ-010 SHALL have port LED_DRIVE in 4, LED current step.
REQ-011 SHALL have ports: DC_Comp in 7, offset DAC code; PGA_Gain in 4, gain code.
REQ-012 SHALL have ports: ADC out 8, sample; ADC_Valid out 1, sample tracks settings; Sat_Hi out 1; Sat_Lo out 1.

Function
REQ-013 SHALL generate an 8-bit triangle shape: +1 every SHAPE_DIV cycles up to 255, then -1 down to 0; at 255 next step is 254, at 0 next step is 1 (period 510*SHAPE_DIV cycles).
REQ-014 SHALL compute photocurrent pc = LED_RED*(RED_DC*LED_DRIVE + ((shape*RED_AC)>>8)) + LED_IR*(IR_DC*LED_DRIVE + ((shape*IR_AC)>>8)); both LEDs on sum, both off give 0; 14-bit unsigned.
REQ-015 SHALL compute diff = pc - DC_Comp*COMP_SCALE as signed 16-bit, amp = diff*(PGA_Gain+1) as signed 21-bit; no intermediate truncation.
REQ-016 SHALL saturate: amp<0 -> ADC=0, Sat_Lo=1; amp>255 -> ADC=255, Sat_Hi=1; else ADC=amp[7:0], both flags 0.
REQ-017 SHALL pipeline two stages (stage 1 registers amp, stage 2 registers ADC/flags): ADC reflects inputs sampled 2 cycles earlier.
REQ-018 SHALL implement FSM states SETTLE and TRACK; a change on any of LED_RED, LED_IR, LED_DRIVE, DC_Comp, PGA_Gain versus its previous-cycle registered value is a "setting change".
REQ-019 SHALL in TRACK on setting change go to SETTLE, load counter with SETTLE_CYCLES, drop ADC_Valid the next cycle.
REQ-020 SHALL in SETTLE hold ADC, Sat_Hi, Sat_Lo frozen, ADC_Valid=0, decrement counter; a further setting change reloads counter; go to TRACK when counter reaches 0 with no change that cycle.
REQ-021 SHALL assert ADC_Valid exactly 2 cycles after entering TRACK (pipeline refill), with ADC updated every cycle from then on.
REQ-022 SHALL keep the shape generator running through SETTLE, independent of FSM state.

Reset
REQ-023 SHALL on rst_n low asynchronously clear ADC, Sat_Hi, Sat_Lo, ADC_Valid, shape (direction up), pipeline, previous-input registers to 0, and enter SETTLE with counter=SETTLE_CYCLES.
REQ-024 SHALL on reset mid-SETTLE or mid-TRACK discard all in-flight samples; no ADC_Valid before SETTLE_CYCLES+2 cycles after release.

Configuration
REQ-025 SHALL with PPG_NOISE_EN defined add a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 at reset, steps every cycle) and add signed (lfsr[2:0]-4) to diff before gain.
REQ-026 SHALL without PPG_NOISE_EN contain no LFSR, output fully deterministic.

Structure
REQ-027 SHALL place parameter defaults, FSM state enum, and pipeline-latency constant (2) in shared package ppg_pkg.
REQ-028 SHALL implement the triangle generator as sub-module ppg_shape_gen (CLK, rst_n, shape out 8).

Verification (noise off, defaults)
REQ-029 SHALL check LED_RED=1, LED_DRIVE=10, DC_Comp=110, PGA_Gain=0, shape held 0 -> ADC=120, flags 0, ADC_Valid after 10 cycles.
REQ-030 SHALL check same with PGA_Gain=1 -> ADC=240; PGA_Gain=3 -> ADC=255, Sat_Hi=1.
REQ-031 SHALL check DC_Comp=127, PGA_Gain=0, LED_RED=1 -> diff=-16 -> ADC=0, Sat_Lo=1; both LEDs off, any DC_Comp -> ADC=0, Sat_Lo=1 (DC_Comp=0 -> ADC=0, Sat_Lo=0).
REQ-032 SHALL check PGA_Gain toggle in TRACK -> ADC_Valid low next cycle, ADC frozen 8 cycles, Valid high 2 cycles after TRACK; second change at settle cycle 5 -> freeze extends 8 more.
REQ-033 SHALL check shape: 255 -> 254, 0 -> 1, one period 1020 cycles; RED ADC swing equals 39*(PGA_Gain+1) unsaturated.
REQ-034 SHALL check rst_n pulsed mid-TRACK -> all outputs 0 immediately, ADC_Valid returns after exactly 10 cycles.
